// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: checks line/frame/active-window timing, tracks lock and captures pixels.
// Define VGA_MON_CRC_EN to add a per-frame CRC-16-CCITT over active pixels.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iVGA_CLK,
    input  logic        reset,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    input  logic        err_clr,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        pixel_valid,
    output logic [23:0] pixel_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic        lost_lock,
    output logic        err_h,
    output logic        err_v,
    output logic        err_act,
    output logic [15:0] frame_crc
);
    localparam logic [1:0]  ST_SEARCH  = 2'd0;
    localparam logic [1:0]  ST_TRACK   = 2'd1;
    localparam logic [1:0]  ST_LOCKED  = 2'd2;
    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
    localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [8:0]  V_ACTIVE_C = 9'(V_ACTIVE);
    localparam logic [7:0]  LOCK_C     = 8'(LOCK_FRAMES);

    logic        hs_q, vs_q, blank_q;
    logic [10:0] clk_cnt_q, clk_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [8:0]  pixel_y_q, pixel_y_d;
    logic        pixel_valid_q;
    logic [23:0] pixel_rgb_q;
    logic [1:0]  state_q, state_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic        h_armed_q, h_armed_d;
    logic        frame_done_q, frame_done_d;
    logic        lost_lock_q, lost_lock_d;
    logic        err_h_q, err_h_d, err_v_q, err_v_d, err_act_q, err_act_d;
    logic        line_start, frame_start, blank_rise, blank_fall, tracking;
    logic        ev_h, ev_v, ev_act, ev_any;

    always_comb begin
        line_start  = hs_q & ~iHS;
        frame_start = vs_q & ~iVS;
        blank_rise  = ~blank_q & iBLANK_n;
        blank_fall  = blank_q & ~iBLANK_n;
        tracking    = (state_q != ST_SEARCH);

        // The first line start seen while tracking only arms the line-length check.
        ev_h   = tracking & h_armed_q & line_start & (clk_cnt_q != H_TOTAL_C);
        ev_v   = tracking & frame_start & (line_cnt_q != V_TOTAL_C);
        ev_act = tracking & ((blank_fall & (({1'b0, pixel_x_q} + 11'd1) != H_ACTIVE_C))
                           | (frame_start & (pixel_y_q != V_ACTIVE_C)));
        ev_any = ev_h | ev_v | ev_act;

        clk_cnt_d = line_start ? 11'd1 :
                    ((clk_cnt_q == 11'h7FF) ? clk_cnt_q : clk_cnt_q + 11'd1);
        if (frame_start)
            line_cnt_d = line_start ? 10'd1 : 10'd0;
        else if (line_start && (line_cnt_q != 10'h3FF))
            line_cnt_d = line_cnt_q + 10'd1;
        else
            line_cnt_d = line_cnt_q;

        pixel_x_d = blank_rise ? 10'd0 : (iBLANK_n ? pixel_x_q + 10'd1 : pixel_x_q);
        pixel_y_d = frame_start ? 9'd0 : (blank_fall ? pixel_y_q + 9'd1 : pixel_y_q);

        err_h_d   = (err_h_q & ~err_clr) | ev_h;
        err_v_d   = (err_v_q & ~err_clr) | ev_v;
        err_act_d = (err_act_q & ~err_clr) | ev_act;
        h_armed_d = tracking & (h_armed_q | line_start);

        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        frame_err_d  = frame_err_q;
        lost_lock_d  = 1'b0;
        frame_done_d = frame_start & tracking;
        case (state_q)
            ST_SEARCH: begin
                if (frame_start) begin
                    state_d     = ST_TRACK;
                    good_cnt_d  = 8'd0;
                    frame_err_d = 1'b0;
                end
            end
            ST_TRACK: begin
                if (ev_any)
                    good_cnt_d = 8'd0;
                if (frame_start) begin
                    frame_err_d = 1'b0;
                    if (!ev_any && !frame_err_q) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if ((good_cnt_q + 8'd1) >= LOCK_C)
                            state_d = ST_LOCKED;
                    end
                end else if (ev_any) begin
                    frame_err_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (ev_any) begin
                    state_d     = ST_SEARCH;
                    lost_lock_d = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            blank_q       <= 1'b0;
            clk_cnt_q     <= 11'd0;
            line_cnt_q    <= 10'd0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 9'd0;
            pixel_valid_q <= 1'b0;
            pixel_rgb_q   <= 24'd0;
            state_q       <= ST_SEARCH;
            good_cnt_q    <= 8'd0;
            frame_err_q   <= 1'b0;
            h_armed_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            lost_lock_q   <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            err_act_q     <= 1'b0;
        end else begin
            hs_q          <= iHS;
            vs_q          <= iVS;
            blank_q       <= iBLANK_n;
            clk_cnt_q     <= clk_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_valid_q <= iBLANK_n;
            pixel_rgb_q   <= {r_in, g_in, b_in};
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            frame_err_q   <= frame_err_d;
            h_armed_q     <= h_armed_d;
            frame_done_q  <= frame_done_d;
            lost_lock_q   <= lost_lock_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
            err_act_q     <= err_act_d;
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

    // Bit-serial CCITT step over one 24-bit pixel, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) != 1'b0) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always_comb begin
        crc_d = frame_start ? 16'hFFFF : crc_q;
        if (iBLANK_n)
            crc_d = crc_step(crc_d, {r_in, g_in, b_in});
        frame_crc_d = frame_start ? crc_q : frame_crc_q;
    end

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_rgb   = pixel_rgb_q;
    assign locked      = (state_q == ST_LOCKED);
    assign frame_done  = frame_done_q;
    assign lost_lock   = lost_lock_q;
    assign err_h       = err_h_q;
    assign err_v       = err_v_q;
    assign err_act     = err_act_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: scaled-down video timing, per-cycle reference model plus literal checks.
`timescale 1ns/1ps
module tb_vga_sync_monitor;
    localparam int HT = 40, HA = 16, VT = 20, VA = 8, LF = 2;
    localparam int HS_W = 4, H_ACT0 = 8, VS_W = 2, V_ACT0 = 5;
`ifdef VGA_MON_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, hs = 1'b1, vs = 1'b1, blank = 1'b0, clr = 1'b0;
    logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic pixel_valid, locked, frame_done, lost_lock, err_h, err_v, err_act;
    logic [23:0] pixel_rgb;
    logic [15:0] frame_crc;

    vga_sync_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(LF)) dut (
        .iVGA_CLK(clk), .reset(rst), .iHS(hs), .iVS(vs), .iBLANK_n(blank),
        .r_in(r), .g_in(g), .b_in(b), .err_clr(clr),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
        .locked(locked), .frame_done(frame_done), .lost_lock(lost_lock),
        .err_h(err_h), .err_v(err_v), .err_act(err_act), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    bit clr_req = 1'b0;

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Byte-wise CCITT update for one {r,g,b} pixel.
    function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] px);
        logic [15:0] x;
        x = c;
        for (int k = 0; k < 3; k++) begin
            x = x ^ {px[23-8*k -: 8], 8'h00};
            for (int j = 0; j < 8; j++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        end
        return x;
    endfunction

    // Reference model: timestamps and event counts, mode 0=search 1=track 2=locked.
    int m_mode = 0, m_good = 0, m_x = 0, m_y = 0, m_lines = 0, m_cyc = 0, m_last_ls = 0;
    bit m_ferr, m_hskip, p_hs, p_vs, p_blank, m_valid, m_fd, m_ll, m_eh, m_ev, m_ea;
    bit ls, fs, br, bf, trk, e_h, e_v, e_a, e_any;
    logic [23:0] m_rgb;
    logic [15:0] m_crc, m_fcrc, exp_crc;
    logic [65:0] act_v, exp_v;
    int lost_cnt = 0, run_max = 0, min_run_max = 1023;
    bit prev_valid = 1'b0;

    always @(posedge clk) begin
        #1;
        m_cyc++;
        if (rst) begin
            m_mode = 0; m_good = 0; m_x = 0; m_y = 0; m_lines = 0; m_ferr = 0; m_hskip = 1;
            p_hs = 0; p_vs = 0; p_blank = 0; m_valid = 0; m_rgb = 24'd0; m_fd = 0; m_ll = 0;
            m_eh = 0; m_ev = 0; m_ea = 0; m_crc = 16'hFFFF; m_fcrc = 16'h0000;
        end else begin
            ls = p_hs && !hs; fs = p_vs && !vs; br = !p_blank && blank; bf = p_blank && !blank;
            trk = (m_mode != 0);
            e_h = ls && trk && !m_hskip && ((m_cyc - m_last_ls) != HT);
            e_v = fs && trk && (m_lines != VT);
            e_a = trk && ((bf && (m_x + 1 != HA)) || (fs && (m_y != VA)));
            e_any = e_h || e_v || e_a;
            m_eh = (m_eh && !clr) || e_h;
            m_ev = (m_ev && !clr) || e_v;
            m_ea = (m_ea && !clr) || e_a;
            if (fs) m_lines = ls ? 1 : 0; else if (ls) m_lines++;
            if (ls) m_last_ls = m_cyc;
            if (!trk) m_hskip = 1; else if (ls) m_hskip = 0;
            if (br) m_x = 0; else if (blank) m_x = (m_x + 1) % 1024;
            if (fs) m_y = 0; else if (bf) m_y++;
            m_valid = blank; m_rgb = {r, g, b};
            if (fs) begin m_fcrc = m_crc; m_crc = 16'hFFFF; end
            if (blank) m_crc = crc_px(m_crc, {r, g, b});
            m_fd = fs && trk; m_ll = 0;
            case (m_mode)
                0: if (fs) begin m_mode = 1; m_good = 0; m_ferr = 0; end
                1: begin
                    if (e_any) m_good = 0;
                    if (fs) begin
                        if (!m_ferr && !e_any) m_good++;
                        m_ferr = 0;
                        if (m_good >= LF) m_mode = 2;
                    end else if (e_any) m_ferr = 1;
                end
                default: if (e_any) begin m_mode = 0; m_ll = 1; end
            endcase
            p_hs = hs; p_vs = vs; p_blank = blank;
        end
        exp_crc = CRC_ON ? m_fcrc : 16'h0000;
        exp_v = {10'(m_x), 9'(m_y), m_valid, m_rgb, (m_mode == 2), m_fd, m_ll, m_eh, m_ev, m_ea, exp_crc};
        act_v = {pixel_x, pixel_y, pixel_valid, pixel_rgb, locked, frame_done, lost_lock,
                 err_h, err_v, err_act, frame_crc};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle %0d outputs: got %h expected %h", m_cyc, act_v, exp_v);
        if (lost_lock === 1'b1) lost_cnt++;
        if (pixel_valid === 1'b1 && int'(pixel_x) > run_max) run_max = int'(pixel_x);
        if (prev_valid && pixel_valid !== 1'b1) begin
            if (run_max < min_run_max) min_run_max = run_max;
            run_max = 0;
        end
        prev_valid = (pixel_valid === 1'b1);
    end

    task automatic drive(input bit h, input bit v, input bit bl, input logic [23:0] px);
        @(negedge clk);
        hs = h; vs = v; blank = bl; {r, g, b} = px; clr = clr_req; clr_req = 1'b0;
    endtask

    task automatic send_line(input int li, input int len, input int act_len, input bit solid, input int ncyc);
        bit act;
        logic [23:0] px;
        for (int c = 0; c < len && c < ncyc; c++) begin
            act = (li >= V_ACT0) && (li < V_ACT0 + VA) && (c >= H_ACT0) && (c < H_ACT0 + act_len);
            px = (act && solid) ? 24'hFF0000 : 24'($urandom);
            drive(c >= HS_W, li >= VS_W, act, px);
        end
    endtask

    task automatic send_frame(input int nl, input int bad_h, input int bad_a, input bit solid);
        for (int li = 0; li < nl; li++)
            send_line(li, (li == bad_h) ? HT - 1 : HT, (li == bad_a) ? HA - 1 : HA, solid, HT);
    endtask

    initial begin
        logic [15:0] solid_crc;
        int kind;
        rst = 1'b1;
        repeat (3) drive(1, 1, 0, 24'h0);
        check_lit("reset_pixel_x", 32'(pixel_x), 32'd0);
        check_lit("reset_valid", 32'(pixel_valid), 32'd0);
        check_lit("reset_locked", 32'(locked), 32'd0);
        check_lit("reset_errs", 32'({err_h, err_v, err_act}), 32'd0);
        check_lit("reset_crc", 32'(frame_crc), 32'd0);
        rst = 1'b0;
        repeat (4) drive(1, 1, 0, 24'h0);

        send_frame(VT, -1, -1, 0);
        send_frame(VT, -1, -1, 0);
        check_lit("locked_after_2", 32'(locked), 32'd0);
        send_frame(VT, -1, -1, 0);
        check_lit("locked_at_3rd_start", 32'(locked), 32'd1);
        check_lit("nominal_no_errs", 32'({err_h, err_v, err_act}), 32'd0);

        send_frame(VT, 7, -1, 0);
        check_lit("short_line_err_h", 32'(err_h), 32'd1);
        check_lit("short_line_unlock", 32'(locked), 32'd0);
        check_lit("lost_lock_pulses", 32'(lost_cnt), 32'd1);

        send_frame(VT, -1, -1, 0);
        send_frame(VT, -1, -1, 0);
        send_frame(VT - 1, -1, -1, 0);
        send_frame(VT, -1, -1, 0);
        check_lit("short_frame_err_v", 32'(err_v), 32'd1);
        check_lit("lost_lock_pulses2", 32'(lost_cnt), 32'd2);
        clr_req = 1'b1;
        send_frame(VT, -1, -1, 0);
        check_lit("err_v_cleared", 32'(err_v), 32'd0);
        check_lit("err_h_cleared", 32'(err_h), 32'd0);

        send_frame(VT, -1, -1, 0);
        min_run_max = 1023;
        send_frame(VT, -1, V_ACT0 + 3, 0);
        check_lit("short_active_err_act", 32'(err_act), 32'd1);
        check_lit("short_active_max_x", 32'(min_run_max), 32'(HA - 2));

        clr_req = 1'b1;
        send_frame(VT, -1, -1, 1);
        send_frame(VT, -1, -1, 0);
        solid_crc = 16'hFFFF;
        for (int i = 0; i < HA * VA; i++) solid_crc = crc_px(solid_crc, 24'hFF0000);
        check_lit("solid_frame_crc", 32'(frame_crc), CRC_ON ? 32'(solid_crc) : 32'd0);

        for (int li = 0; li < 10; li++) send_line(li, HT, HA, 0, HT);
        send_line(10, HT, HA, 0, 20);
        rst = 1'b1;
        repeat (3) drive(1, 1, 0, 24'h0);
        rst = 1'b0;
        repeat (5) drive(1, 1, 0, 24'h0);
        send_frame(VT, -1, -1, 0);
        send_frame(VT, -1, -1, 0);
        check_lit("post_reset_not_locked", 32'(locked), 32'd0);
        send_frame(VT, -1, -1, 0);
        check_lit("post_reset_locked", 32'(locked), 32'd1);
        check_lit("post_reset_no_errs", 32'({err_h, err_v, err_act}), 32'd0);

        for (int f = 0; f < 14; f++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) clr_req = 1'b1;
            case (kind)
                6: send_frame(VT, $urandom_range(0, VT - 1), -1, 0);
                7: send_frame(($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1, -1, -1, 0);
                8: send_frame(VT, -1, $urandom_range(V_ACT0, V_ACT0 + VA - 1), 0);
                9: send_frame(VT, -1, -1, 1);
                default: send_frame(VT, -1, -1, 0);
            endcase
        end
        repeat (3) drive(1, 1, 0, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
